rgmii_tx_ddr_seq: RTL
=====================

# rgmii_tx_ddr_seq

Transmit-side sequencer for an RGMII PHY interface. It accepts a GMII-style byte stream from the MAC and drives the d1/d2 inputs of the generic DDR output registers (one per TXD bit, one for TX_CTL, one for TXC) at 1000, 100 or 10 Mb/s. At 10/100 it also generates the MAC byte-strobe cadence and the divided TX clock pattern. It sits between the MAC TX path and the ODDR primitives that drive the PHY pins.

## Interface
Parameters:
- none (clk is fixed at 125 MHz nominal; divider constants below are hard-coded)

Ports:
- clk  in  1  125 MHz transmit clock; also clocks the downstream ODDRs
- rst  in  1  synchronous, active-high reset
- speed  in  2  2'b00 = 10M, 2'b01 = 100M, 2'b10 or 2'b11 = 1000M
- gmii_txd  in  8  MAC transmit byte
- gmii_tx_en  in  1  MAC transmit enable
- gmii_tx_er  in  1  MAC transmit error
- mac_gmii_tx_clk_en  out  1  byte strobe; MAC inputs are sampled on cycles where this is 1
- txd_d1  out  4  ODDR rising-half data for TXD[3:0]
- txd_d2  out  4  ODDR falling-half data for TXD[3:0]
- txctl_d1  out  1  ODDR rising-half data for TX_CTL
- txctl_d2  out  1  ODDR falling-half data for TX_CTL
- txc_d1  out  1  ODDR rising-half data for TXC
- txc_d2  out  1  ODDR falling-half data for TXC
- speed_active  out  2  currently latched speed, normalised (2'b11 reported as 2'b10)

## Operation
- State: cycle counter cnt (0..LAST), nibble phase ph (0/1), latched speed spd, registered byte/en/er.
- LAST: 1000M = 0; 100M = 4; 10M = 49.
- cnt increments each cycle and wraps LAST->0. On wrap, ph toggles (10/100 only; ph is held at 0 at 1000M).
- Strobe: at 1000M, mac_gmii_tx_clk_en = 1 every cycle. At 10/100, it is 1 only on the cycle where cnt==LAST and ph==1, i.e. once per two TX clock periods.
- On a strobe cycle: the byte register loads gmii_txd, the en register loads gmii_tx_en, and the er register loads gmii_tx_er.
- TXC pattern (txc_d1, txc_d2):
  - 1000M: (1,0) every cycle.
  - 100M: cnt 0,1 -> (1,1); cnt 2 -> (1,0); cnt 3,4 -> (0,0). This gives 5 high half-cycles and 5 low half-cycles = 25 MHz, 50% duty.
  - 10M: cnt<25 -> (1,1); else (0,0). This gives 2.5 MHz, 50% duty.
- TXD:
  - 1000M: d1 = byte[3:0], d2 = byte[7:4].
  - 10/100: d1 = d2 = (ph==0 ? byte[3:0] : byte[7:4]). The low nibble goes in the first TXC period of a byte, the high nibble in the second.
- TX_CTL: for each half x, txctl_dx = txc_dx ? en : (en ^ er). TX_EN is therefore presented while TXC is high and TX_EN^TX_ER while TXC is low, at all speeds.
- Speed change:
  - The speed input is latched into spd only on a strobe cycle where gmii_tx_en==0 and gmii_tx_er==0 (idle byte).
  - If the latched value differs from spd, cnt and ph clear to 0 on the next cycle.
  - Speed changes mid-frame are ignored until the next idle strobe.

## Timing
- All outputs are registered.
- Reset behaviour:
  - While rst=1: every output is 0, cnt=0, ph=0, and the byte/en/er registers are 0.
  - spd loads from speed (normalised) each cycle during reset.
  - speed_active reflects spd one cycle later.
- First cycle after reset release: outputs show the cnt=0, ph=0 pattern with byte=0, en=0.
- Latency, 1000M: a byte sampled on strobe cycle N appears on txd_d1/d2 and txctl_d1/d2 in cycle N+1, and is held for exactly 1 cycle.
- Latency, 100M: a byte sampled at cnt=4, ph=1 appears as the low nibble from the next cycle (cnt=0, ph=0) for 5 cycles, then as the high nibble for 5 cycles.
- Latency, 10M: same structure as 100M, but each nibble is held for 50 cycles.
- MAC rule: the MAC must hold its inputs stable until a strobe cycle. Input values on non-strobe cycles are ignored.
- TX clock alignment: TXC rising edges coincide with cnt==0. Data changes only at cnt==0, so TXD is stable across every TXC edge at 10/100.
- Mid-operation reset: an rst pulse on any cycle returns to the reset state on the following cycle. Any partially sent nibble is abandoned.

## Test plan
- 1000M stream:
  - Stimulus: speed=2'b10; drive bytes 0x55, 0xD5, 0xA3 with en=1.
  - Required: strobe every cycle; one cycle later txd_d1/d2 = 5/5, 5/D, 3/A; txctl=(1,1); txc=(1,0).
- 100M cadence:
  - Stimulus: speed=2'b01; send byte 0x3C with en=1.
  - Required: strobe period is 10 cycles; txd_d1=txd_d2=0xC for 5 cycles, then 0x3 for 5 cycles; txc sequence per 5 cycles is (1,1),(1,1),(1,0),(0,0),(0,0).
- 10M cadence:
  - Stimulus: speed=2'b00.
  - Required: strobe period is 100 cycles; txc=(1,1) for 25 cycles then (0,0) for 25 cycles; each nibble is held for 50 cycles.
- Error signalling:
  - Stimulus: 1000M, byte 0x0F with en=1, er=1.
  - Required: txctl=(1,0).
  - Stimulus: en=0, er=1 at 100M.
  - Required: txctl=(0,0) at cnt 0..1, (0,1) at cnt 2, (1,1) at cnt 3..4.
- Speed change gating:
  - Stimulus: at 1000M with en=1, change speed to 2'b01 mid-frame.
  - Required: speed_active stays 2'b10 until the first strobe with en=0 and er=0; the next cycle has cnt=0, ph=0, and the 100M cadence starts.
- Reset mid-frame:
  - Stimulus: at 10M, assert rst at cnt=30, ph=1 for 1 cycle.
  - Required: all outputs are 0 during rst; after release, txc=(1,1) from cnt=0, and the first strobe occurs 100 cycles after release.

Source files
------------

// File: rtl/rgmii_tx_ddr_seq.sv
// RGMII transmit sequencer: turns a GMII byte stream into ODDR d1/d2 data for
// TXD, TX_CTL and TXC at 1000/100/10 Mb/s, including the 10/100 byte cadence.
module rgmii_tx_ddr_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    output logic       mac_gmii_tx_clk_en,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       txctl_d1,
    output logic       txctl_d2,
    output logic       txc_d1,
    output logic       txc_d2,
    output logic [1:0] speed_active
);

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;

    function automatic logic [1:0] norm_speed(input logic [1:0] s);
        return s[1] ? SPD_1000 : s;
    endfunction

    function automatic logic [5:0] last_cnt(input logic [1:0] s);
        case (s)
            SPD_10:  return 6'd49;
            SPD_100: return 6'd4;
            default: return 6'd0;
        endcase
    endfunction

    // Sequencer state
    logic [5:0] cnt_q, cnt_n;
    logic       ph_q, ph_n;
    logic [1:0] spd_q, spd_n;
    logic [7:0] data_q, data_n;
    logic       en_q, en_n;
    logic       er_q, er_n;
    logic       run_q;

    // Output-register next values
    logic       strobe_n;
    logic [3:0] txd1_n, txd2_n;
    logic [3:0] nib_n;
    logic       txc1_n, txc2_n;
    logic       ctl1_n, ctl2_n;
    logic       is_gig_n;

    // Handshake: mac_gmii_tx_clk_en is a registered strobe; the MAC holds its
    // byte/en/er stable and they are captured on the clock edge that ends a
    // cycle in which the strobe is 1. There is no back-pressure beyond that.
    // run_q stays 0 for the first cycle after reset so the counter shows
    // cnt=0 on the first live cycle instead of skipping it.
    always_comb begin
        cnt_n  = cnt_q;
        ph_n   = ph_q;
        spd_n  = spd_q;
        data_n = data_q;
        en_n   = en_q;
        er_n   = er_q;
        if (run_q) begin
            if (cnt_q == last_cnt(spd_q)) begin
                cnt_n = 6'd0;
                if (spd_q != SPD_1000) begin
                    ph_n = ~ph_q;
                end
            end else begin
                cnt_n = cnt_q + 6'd1;
            end

            if (mac_gmii_tx_clk_en) begin
                data_n = gmii_txd;
                en_n   = gmii_tx_en;
                er_n   = gmii_tx_er;
                // Speed only follows the input on idle bytes; a change restarts the cadence.
                if (!gmii_tx_en && !gmii_tx_er) begin
                    spd_n = norm_speed(speed);
                    if (spd_n != spd_q) begin
                        cnt_n = 6'd0;
                        ph_n  = 1'b0;
                    end
                end
            end
        end
    end

    // Outputs are a function of the state that will be current next cycle,
    // so the registered pins always match the live cnt/ph/byte.
    always_comb begin
        is_gig_n = (spd_n == SPD_1000);
        strobe_n = is_gig_n || ((cnt_n == last_cnt(spd_n)) && ph_n);

        txc1_n = 1'b1;
        txc2_n = 1'b0;
        case (spd_n)
            SPD_10: begin
                txc1_n = (cnt_n < 6'd25);
                txc2_n = (cnt_n < 6'd25);
            end
            SPD_100: begin
                txc1_n = (cnt_n < 6'd3);
                txc2_n = (cnt_n < 6'd2);
            end
            default: begin
                txc1_n = 1'b1;
                txc2_n = 1'b0;
            end
        endcase

        nib_n  = ph_n ? data_n[7:4] : data_n[3:0];
        txd1_n = is_gig_n ? data_n[3:0] : nib_n;
        txd2_n = is_gig_n ? data_n[7:4] : nib_n;

        ctl1_n = txc1_n ? en_n : (en_n ^ er_n);
        ctl2_n = txc2_n ? en_n : (en_n ^ er_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q              <= 6'd0;
            ph_q               <= 1'b0;
            spd_q              <= norm_speed(speed);
            data_q             <= 8'd0;
            en_q               <= 1'b0;
            er_q               <= 1'b0;
            run_q              <= 1'b0;
            mac_gmii_tx_clk_en <= 1'b0;
            txd_d1             <= 4'd0;
            txd_d2             <= 4'd0;
            txctl_d1           <= 1'b0;
            txctl_d2           <= 1'b0;
            txc_d1             <= 1'b0;
            txc_d2             <= 1'b0;
        end else begin
            cnt_q              <= cnt_n;
            ph_q               <= ph_n;
            spd_q              <= spd_n;
            data_q             <= data_n;
            en_q               <= en_n;
            er_q               <= er_n;
            run_q              <= 1'b1;
            mac_gmii_tx_clk_en <= strobe_n;
            txd_d1             <= txd1_n;
            txd_d2             <= txd2_n;
            txctl_d1           <= ctl1_n;
            txctl_d2           <= ctl2_n;
            txc_d1             <= txc1_n;
            txc_d2             <= txc2_n;
        end
    end

    // Reported speed trails the latched speed by one cycle, including in reset.
    always_ff @(posedge clk) begin
        speed_active <= spd_q;
    end

endmodule
